// File: rtl/cardinal_nic_fifo.sv
// Cardinal ring NIC: ring-to-CPU input FIFO and CPU-to-ring output FIFO,
// with memory-mapped data/status registers and polarity-gated injection.
module cardinal_nic_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [0:DATA_WIDTH-1] word_t;

    word_t in_mem_q  [DEPTH];
    word_t out_mem_q [DEPTH];

    logic [PW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [PW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

    logic  in_full, in_empty, out_full, out_empty;
    logic  cpu_rd, cpu_wr;
    logic  in_push, in_pop, out_push, out_pop;
    word_t out_head;

    always_comb begin
        in_full   = (in_cnt_q == CW'(DEPTH));
        in_empty  = (in_cnt_q == '0);
        out_full  = (out_cnt_q == CW'(DEPTH));
        out_empty = (out_cnt_q == '0);
        cpu_rd    = nicEn & ~nicEnWr;
        cpu_wr    = nicEn & nicEnWr;
        out_head  = out_mem_q[out_rp_q];

        net_ri = reset & ~in_full;
        // Inject only on the router phase opposite to the packet's VC bit.
        net_so = reset & ~out_empty & net_ro & (out_head[0] != net_polarity);
        net_do = net_so ? out_head : '0;

        in_push  = net_si & net_ri;
        in_pop   = cpu_rd & (addr == 2'b00) & ~in_empty;
        out_push = cpu_wr & (addr == 2'b10) & ~out_full;
        out_pop  = net_so;

        d_out = '0;
        if (reset && cpu_rd) begin
            unique case (addr)
                2'b00:   d_out = in_empty ? '0 : in_mem_q[in_rp_q];
                2'b01:   d_out = DATA_WIDTH'(in_cnt_q);
                2'b11:   d_out = DATA_WIDTH'(out_cnt_q);
                default: d_out = '0;
            endcase
        end

        in_wp_d   = in_wp_q + PW'(in_push);
        in_rp_d   = in_rp_q + PW'(in_pop);
        in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
        out_wp_d  = out_wp_q + PW'(out_push);
        out_rp_d  = out_rp_q + PW'(out_pop);
        out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    end

    always_ff @(posedge clk) begin
        if (in_push)  in_mem_q[in_wp_q]   <= net_di;
        if (out_push) out_mem_q[out_wp_q] <= d_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            in_wp_q   <= in_wp_d;
            in_rp_q   <= in_rp_d;
            in_cnt_q  <= in_cnt_d;
            out_wp_q  <= out_wp_d;
            out_rp_q  <= out_rp_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Scoreboard bench for cardinal_nic_fifo: queue-based reference model,
// directed corner cases followed by randomized traffic.
module tb_cardinal_nic_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    typedef logic [0:DW-1] word_t;

    typedef struct {
        logic  ri;
        logic  so;
        word_t dv;
        word_t dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:1] addr;
    word_t      d_in, d_out, net_di, net_do;
    logic       nicEn, nicEnWr, net_si, net_ri, net_so, net_ro, net_polarity;

    int pass_cnt = 0;
    int total_cnt = 0;

    word_t in_q[$];
    word_t out_q[$];
    exp_t  sb[$];

    cardinal_nic_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, word_t act, word_t exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endfunction

    // Monitor: consumes one expected record per driven cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("net_ri", word_t'(net_ri), word_t'(e.ri));
            chk("net_so", word_t'(net_so), word_t'(e.so));
            chk("net_do", net_do, e.dv);
            chk("d_out", d_out, e.dout);
        end
    end

    task automatic cyc(input logic en, input logic wr, input logic [1:0] a,
                       input word_t din, input logic si, input word_t di,
                       input logic ro, input logic pol);
        exp_t e;
        logic in_pop, out_pop, in_acc, out_acc;
        @(posedge clk);
        #1;
        nicEn = en; nicEnWr = wr; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;

        e.ri   = (in_q.size() < DEPTH);
        e.so   = (out_q.size() > 0) && ro && (out_q[0][0] != pol);
        e.dv   = e.so ? out_q[0] : '0;
        e.dout = '0;
        if (en && !wr) begin
            case (a)
                2'd0: e.dout = (in_q.size() > 0) ? in_q[0] : '0;
                2'd1: e.dout = word_t'(in_q.size());
                2'd3: e.dout = word_t'(out_q.size());
                default: e.dout = '0;
            endcase
        end
        sb.push_back(e);

        in_pop  = en && !wr && a == 2'd0 && in_q.size() > 0;
        in_acc  = si && e.ri;
        out_acc = en && wr && a == 2'd2 && out_q.size() < DEPTH;
        out_pop = e.so;
        if (in_pop)  void'(in_q.pop_front());
        if (out_pop) void'(out_q.pop_front());
        if (in_acc)  in_q.push_back(di);
        if (out_acc) out_q.push_back(din);
    endtask

    task automatic idle();
        cyc(0, 0, 2'd0, '0, 0, '0, 0, 0);
    endtask

    function automatic word_t rnd_pkt();
        return {$urandom, $urandom};
    endfunction

    task automatic reset_mid();
        @(posedge clk);
        #1;
        nicEn = 1; nicEnWr = 0; addr = 2'b01; net_si = 0; net_ro = 1;
        net_polarity = 0;
        reset = 1'b0;
        #1;
        chk("rst_so", word_t'(net_so), '0);
        chk("rst_ri", word_t'(net_ri), '0);
        chk("rst_do", net_do, '0);
        chk("rst_dout01", d_out, '0);
        addr = 2'b11;
        #1;
        chk("rst_dout11", d_out, '0);
        in_q.delete();
        out_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        word_t p;
        reset = 1'b0; addr = '0; d_in = '0; nicEn = 0; nicEnWr = 0;
        net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
        #3;
        chk("init_so", word_t'(net_so), '0);
        chk("init_ri", word_t'(net_ri), '0);
        chk("init_do", net_do, '0);
        chk("init_dout", d_out, '0);
        #19;
        reset = 1'b1;

        // Status reads just after reset.
        cyc(1, 0, 2'd1, '0, 0, '0, 0, 0);
        cyc(1, 0, 2'd3, '0, 0, '0, 0, 0);

        // Five CPU writes against a stalled ring; the fifth is dropped.
        for (int i = 0; i < 5; i++) cyc(1, 1, 2'd2, rnd_pkt(), 0, '0, 0, 0);
        cyc(1, 0, 2'd3, '0, 0, '0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2'd0, '0, 0, '0, 1, i[0]);
        cyc(1, 0, 2'd3, '0, 0, '0, 0, 0);

        // VC 0 packet waits while polarity matches, leaves when it flips.
        p = rnd_pkt(); p[0] = 1'b0;
        cyc(1, 1, 2'd2, p, 0, '0, 0, 0);
        cyc(0, 0, 2'd0, '0, 0, '0, 1, 0);
        cyc(0, 0, 2'd0, '0, 0, '0, 1, 0);
        cyc(0, 0, 2'd0, '0, 0, '0, 1, 1);
        cyc(1, 0, 2'd3, '0, 0, '0, 1, 1);

        // Ring offers five packets; the fifth waits for a CPU pop.
        begin
            word_t pk[5];
            for (int i = 0; i < 5; i++) pk[i] = rnd_pkt();
            for (int i = 0; i < 5; i++) cyc(0, 0, 2'd0, '0, 1, pk[i], 0, 0);
            cyc(1, 0, 2'd0, '0, 1, pk[4], 0, 0);
            cyc(0, 0, 2'd0, '0, 1, pk[4], 0, 0);
            for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, '0, 0, '0, 0, 0);
            cyc(1, 0, 2'd1, '0, 0, '0, 0, 0);
        end

        // Input at 3 with simultaneous push and pop.
        for (int i = 0; i < 3; i++) cyc(0, 0, 2'd0, '0, 1, rnd_pkt(), 0, 0);
        cyc(1, 0, 2'd0, '0, 1, rnd_pkt(), 0, 0);
        cyc(1, 0, 2'd1, '0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, '0, 0, '0, 0, 0);

        // Output full: write collides with an injection and is dropped.
        for (int i = 0; i < 4; i++) begin
            p = rnd_pkt(); p[0] = 1'b1;
            cyc(1, 1, 2'd2, p, 0, '0, 0, 0);
        end
        cyc(1, 1, 2'd2, rnd_pkt(), 0, '0, 1, 0);
        cyc(1, 0, 2'd3, '0, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'd0, '0, 0, '0, 1, 0);

        // Non-side-effect accesses.
        cyc(1, 0, 2'd2, '0, 0, '0, 0, 0);
        cyc(1, 1, 2'd0, rnd_pkt(), 0, '0, 0, 0);
        cyc(0, 1, 2'd2, rnd_pkt(), 0, '0, 0, 0);
        cyc(1, 0, 2'd3, '0, 0, '0, 0, 0);

        // Two packets in each FIFO, then reset mid-operation.
        for (int i = 0; i < 2; i++) cyc(1, 1, 2'd2, rnd_pkt(), 1, rnd_pkt(), 0, 0);
        cyc(1, 0, 2'd1, '0, 0, '0, 0, 0);
        @(negedge clk);
        reset_mid();
        cyc(1, 0, 2'd1, '0, 0, '0, 0, 0);
        cyc(1, 0, 2'd3, '0, 0, '0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic en, wr, si, ro, pol;
            logic [1:0] a;
            en  = ($urandom_range(0, 3) != 0);
            wr  = $urandom_range(0, 1);
            a   = 2'($urandom_range(0, 3));
            si  = $urandom_range(0, 1);
            ro  = ($urandom_range(0, 3) != 0);
            pol = $urandom_range(0, 1);
            cyc(en, wr, a, rnd_pkt(), si, rnd_pkt(), ro, pol);
        end
        idle();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cardinal_nic_fifo.md
CARDINAL_NIC_FIFO -- requirements
Module: cardinal_nic_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, packet and processor data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per buffer; a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port addr, input, 2 bits [0:1]: processor register select (00 input data, 01 input status, 10 output data, 11 output status).
REQ-006 SHALL have port d_in, input, [0:DATA_WIDTH-1]: processor write data.
REQ-007 SHALL have port d_out, output, [0:DATA_WIDTH-1]: processor read data.
REQ-008 SHALL have port nicEn, input, 1 bit: processor access enable.
REQ-009 SHALL have port nicEnWr, input, 1 bit: write qualifier, meaningful only with nicEn.
REQ-010 SHALL have port net_si, input, 1 bit: ring offers a packet.
REQ-011 SHALL have port net_ri, output, 1 bit: NIC can accept a ring packet.
REQ-012 SHALL have port net_di, input, [0:DATA_WIDTH-1]: ring packet in.
REQ-013 SHALL have port net_so, output, 1 bit: NIC injects a packet.
REQ-014 SHALL have port net_ro, input, 1 bit: ring can accept a packet.
REQ-015 SHALL have port net_do, output, [0:DATA_WIDTH-1]: injected packet.
REQ-016 SHALL have port net_polarity, input, 1 bit: current ring router polarity.

Function
REQ-017 SHALL contain two independent DEPTH-entry circular FIFOs: input (ring to CPU) and output (CPU to ring).
REQ-018 Each FIFO SHALL use read/write pointers that wrap modulo DEPTH, plus an occupancy count of clog2(DEPTH)+1 bits ranging 0..DEPTH.
REQ-019 Full and empty for each FIFO SHALL be derived from the occupancy count at the start of the cycle.
REQ-020 net_ri SHALL equal NOT input-full, combinationally; a push occurs at the clock edge when net_si and net_ri are both 1.
REQ-021 A CPU write (nicEn=1, nicEnWr=1, addr=10) SHALL push d_in into the output FIFO if it is not full; if it is full, the write SHALL be silently dropped.
REQ-022 A CPU read (nicEn=1, nicEnWr=0, addr=00) SHALL drive d_out with the input FIFO head combinationally and pop it at that edge; when the FIFO is empty, d_out SHALL be 0 and no pop SHALL occur.
REQ-023 A status read of addr=01 or addr=11 SHALL return the input or output occupancy count, zero-extended to DATA_WIDTH in the LSBs.
REQ-024 A read of addr=10, a write to addr 00, 01 or 11, nicEnWr with nicEn=0, and any cycle with nicEn=0 SHALL have no side effects; d_out SHALL be 0 in these cases.
REQ-025 Packet bit 0 (MSB) SHALL be the VC bit.
REQ-026 net_so SHALL be 1 iff the output FIFO is non-empty, net_ro=1, and head VC bit differs from net_polarity.
REQ-027 net_do SHALL equal the output FIFO head when net_so=1 and SHALL be 0 otherwise.
REQ-028 The output FIFO head SHALL pop at the edge where net_so=1; at most one injection SHALL occur per cycle.
REQ-029 A simultaneous push and pop on the same FIFO SHALL leave the count unchanged and SHALL preserve FIFO order.
REQ-030 A push into a FIFO that is full at cycle start SHALL be rejected even if a pop occurs in the same cycle.
REQ-031 Packets SHALL leave each FIFO in arrival order with no duplication, loss (other than REQ-021 drops), or modification.

Reset
REQ-032 While reset=0, all pointers and counts SHALL clear immediately (asynchronous), and net_so, net_ri, net_do and d_out SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered packets.
REQ-034 In the first cycle after reset release, net_ri SHALL be 1 and both status reads SHALL return 0.
REQ-035 FIFO storage contents SHALL not require reset.

Verification (DEPTH=4, DATA_WIDTH=64)
REQ-036 Reset pulse -> during reset all outputs are 0; after release net_ri=1, and reads of addr 01 and 11 both return 0.
REQ-037 5 CPU writes to addr 10 with net_ro=0 -> addr 11 reads 4 and the 5th packet is absent; then net_ro=1 with polarity toggling each cycle -> the 4 packets appear in order, each in a cycle where VC differs from polarity.
REQ-038 Head VC=0, net_polarity=0, net_ro=1 -> net_so=0 and net_do=0; net_polarity goes to 1 -> net_so=1 that cycle and the packet pops.
REQ-039 Ring offers 5 consecutive packets -> net_ri=0 after the 4th is accepted and the 5th is held; CPU reads addr 00 -> returns packet 1 and net_ri=1 in the next cycle; remaining reads return packets 2-4 in order.
REQ-040 Input count 3, with net_si=1 and a CPU pop in the same cycle -> count stays 3 and order is intact; output count 4, with a CPU write and an injection in the same cycle -> write dropped, count 3.
REQ-041 Reset asserted with 2 packets in each FIFO -> counts are 0 without waiting for a clock edge, and net_so=0.
